// File: rtl/placar_param.sv
`timescale 1ns/1ps
// placar_param -- two-player match scoreboard with optional win-by-two mode.
//
// Purpose:
//   Counts points for a left and a right player. A point is counted on the
//   rising edge of its request line while scoring is enabled. Input holds
//   count once. When the win condition is met, the winner is latched and the
//   match freezes until novo_jogo or reset.
//
// Parameters:
//   WIDTH          bit width of each score register
//   PONTOS_VITORIA points needed to win (2 .. 2**WIDTH-2)
//   MODO_VANTAGEM  0: first to PONTOS_VITORIA wins
//                  1: the winner also needs a lead of 2 or more
//                     (deuce wraps back to PONTOS_VITORIA-1 all)
//
// Ports:
//   clock            system clock
//   reset            asynchronous active-low reset
//   ponto_esquerda   point request, left player (level, edge-detected)
//   ponto_direita    point request, right player (level, edge-detected)
//   enable           scoring enable (edge registers track regardless)
//   novo_jogo        synchronous match clear, active-high, highest priority
//   placar_esquerda  left score (registered)
//   placar_direita   right score (registered)
//   ganhador         0 in progress, 1 left won, 2 right won (registered)
//   fim_partida      high while the match is over
//   ultimo_ponto     last scorer: 0 none, 1 left, 2 right (registered)
module placar_param #(
  parameter int WIDTH          = 4,
  parameter int PONTOS_VITORIA = 7,
  parameter int MODO_VANTAGEM  = 0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ponto_esquerda,
  input  logic             ponto_direita,
  input  logic             enable,
  input  logic             novo_jogo,
  output logic [WIDTH-1:0] placar_esquerda,
  output logic [WIDTH-1:0] placar_direita,
  output logic [1:0]       ganhador,
  output logic             fim_partida,
  output logic [1:0]       ultimo_ponto
);

  if ((PONTOS_VITORIA < 2) || (PONTOS_VITORIA > (2**WIDTH) - 2)) begin : g_param_check
    $error("placar_param: PONTOS_VITORIA must lie in 2 .. 2**WIDTH-2");
  end

  localparam logic [WIDTH-1:0] PV    = WIDTH'(PONTOS_VITORIA);
  localparam logic [WIDTH-1:0] PV_M1 = WIDTH'(PONTOS_VITORIA - 1);

  typedef enum logic {
    JOGO = 1'b0,
    FIM  = 1'b1
  } estado_t;

  estado_t estado, estado_prox;

  // Previous sampled level of each request line, for rising-edge detection.
  logic ant_esquerda, ant_direita;
  logic ev_esquerda, ev_direita;

  logic [WIDTH-1:0] placar_e_prox, placar_d_prox;
  logic [1:0]       ganhador_prox, ultimo_prox;

  logic [WIDTH-1:0] marcador_novo, adversario;
  logic             vitoria, empate_deuce;

  assign ev_esquerda = enable & ponto_esquerda & ~ant_esquerda;
  assign ev_direita  = enable & ponto_direita  & ~ant_direita;

  assign fim_partida = (estado == FIM);

  // Score the scorer would reach and the opponent's score, used by the
  // win and deuce checks; only meaningful when exactly one event occurs.
  always_comb begin
    marcador_novo = '0;
    adversario    = '0;
    if (ev_esquerda) begin
      marcador_novo = placar_esquerda + WIDTH'(1);
      adversario    = placar_direita;
    end else begin
      marcador_novo = placar_direita + WIDTH'(1);
      adversario    = placar_esquerda;
    end
  end

  always_comb begin
    vitoria      = 1'b0;
    empate_deuce = 1'b0;
    if (MODO_VANTAGEM == 0) begin
      vitoria = (marcador_novo == PV);
    end else begin
      // One extra bit so opponent+2 cannot wrap.
      vitoria = ({1'b0, marcador_novo} >= {1'b0, PV}) &&
                ({1'b0, marcador_novo} >= ({1'b0, adversario} + (WIDTH+1)'(2)));
      empate_deuce = (marcador_novo == adversario) && (marcador_novo >= PV_M1);
    end
  end

  always_comb begin
    estado_prox   = estado;
    placar_e_prox = placar_esquerda;
    placar_d_prox = placar_direita;
    ganhador_prox = ganhador;
    ultimo_prox   = ultimo_ponto;

    if (novo_jogo) begin
      estado_prox   = JOGO;
      placar_e_prox = '0;
      placar_d_prox = '0;
      ganhador_prox = 2'd0;
      ultimo_prox   = 2'd0;
    end else if ((estado == JOGO) && (ev_esquerda ^ ev_direita)) begin
      if (ev_esquerda) begin
        placar_e_prox = marcador_novo;
        ultimo_prox   = 2'd1;
      end else begin
        placar_d_prox = marcador_novo;
        ultimo_prox   = 2'd2;
      end

      if (empate_deuce) begin
        placar_e_prox = PV_M1;
        placar_d_prox = PV_M1;
      end

      if (vitoria) begin
        estado_prox   = FIM;
        ganhador_prox = ev_esquerda ? 2'd1 : 2'd2;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ant_esquerda    <= 1'b0;
      ant_direita     <= 1'b0;
      estado          <= JOGO;
      placar_esquerda <= '0;
      placar_direita  <= '0;
      ganhador        <= 2'd0;
      ultimo_ponto    <= 2'd0;
    end else begin
      ant_esquerda    <= ponto_esquerda;
      ant_direita     <= ponto_direita;
      estado          <= estado_prox;
      placar_esquerda <= placar_e_prox;
      placar_direita  <= placar_d_prox;
      ganhador        <= ganhador_prox;
      ultimo_ponto    <= ultimo_prox;
    end
  end

endmodule

// File: tb/tb_placar_param.sv
`timescale 1ns/1ps
// Bench for placar_param: one default instance (first to 7) and one
// win-by-two instance (PONTOS_VITORIA=4). Expected outputs are queued when
// each step is driven and popped/checked 1 ns after the sampling edge.
module tb_placar_param;

  logic clock = 1'b0;
  always #20 clock = ~clock;

  logic reset;

  logic       a_e, a_d, a_en, a_ng;
  logic [3:0] a_pe, a_pd;
  logic [1:0] a_g, a_u;
  logic       a_f;

  logic       b_e, b_d, b_en, b_ng;
  logic [3:0] b_pe, b_pd;
  logic [1:0] b_g, b_u;
  logic       b_f;

  placar_param #(
    .WIDTH(4), .PONTOS_VITORIA(7), .MODO_VANTAGEM(0)
  ) dut_a (
    .clock(clock), .reset(reset),
    .ponto_esquerda(a_e), .ponto_direita(a_d),
    .enable(a_en), .novo_jogo(a_ng),
    .placar_esquerda(a_pe), .placar_direita(a_pd),
    .ganhador(a_g), .fim_partida(a_f), .ultimo_ponto(a_u)
  );

  placar_param #(
    .WIDTH(4), .PONTOS_VITORIA(4), .MODO_VANTAGEM(1)
  ) dut_b (
    .clock(clock), .reset(reset),
    .ponto_esquerda(b_e), .ponto_direita(b_d),
    .enable(b_en), .novo_jogo(b_ng),
    .placar_esquerda(b_pe), .placar_direita(b_pd),
    .ganhador(b_g), .fim_partida(b_f), .ultimo_ponto(b_u)
  );

  typedef struct {
    string      tag;
    logic [3:0] pe;
    logic [3:0] pd;
    logic [1:0] g;
    logic [1:0] u;
    logic       f;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];

  int n_cmp = 0;
  int n_bad = 0;

  task automatic cmp(input string tag, input string field,
                     input logic [3:0] act, input logic [3:0] exp);
    n_cmp++;
    assert (act === exp) else begin
      n_bad++;
      $error("FAIL %s.%s: observed %0d expected %0d", tag, field, act, exp);
    end
  endtask

  task automatic drive(input bit sel, input logic e, input logic d,
                       input logic en, input logic ng);
    if (sel == 1'b0) begin
      a_e = e; a_d = d; a_en = en; a_ng = ng;
    end else begin
      b_e = e; b_d = d; b_en = en; b_ng = ng;
    end
  endtask

  task automatic push_exp(input bit sel, input string tag,
                          input logic [3:0] xpe, input logic [3:0] xpd,
                          input logic [1:0] xg, input logic [1:0] xu,
                          input logic xf);
    exp_t x;
    x.tag = tag; x.pe = xpe; x.pd = xpd; x.g = xg; x.u = xu; x.f = xf;
    if (sel == 1'b0) q_a.push_back(x);
    else             q_b.push_back(x);
  endtask

  task automatic check_pop(input bit sel);
    exp_t x;
    if (((sel == 1'b0) ? q_a.size() : q_b.size()) == 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL scoreboard: observed empty queue expected an entry");
    end else begin
      if (sel == 1'b0) begin
        x = q_a.pop_front();
        cmp(x.tag, "placar_esquerda", a_pe, x.pe);
        cmp(x.tag, "placar_direita",  a_pd, x.pd);
        cmp(x.tag, "ganhador",        {2'b00, a_g}, {2'b00, x.g});
        cmp(x.tag, "ultimo_ponto",    {2'b00, a_u}, {2'b00, x.u});
        cmp(x.tag, "fim_partida",     {3'b000, a_f}, {3'b000, x.f});
      end else begin
        x = q_b.pop_front();
        cmp(x.tag, "placar_esquerda", b_pe, x.pe);
        cmp(x.tag, "placar_direita",  b_pd, x.pd);
        cmp(x.tag, "ganhador",        {2'b00, b_g}, {2'b00, x.g});
        cmp(x.tag, "ultimo_ponto",    {2'b00, b_u}, {2'b00, x.u});
        cmp(x.tag, "fim_partida",     {3'b000, b_f}, {3'b000, x.f});
      end
    end
  endtask

  // Drive inputs, queue the outputs expected after the next rising edge,
  // then check them 1 ns after that edge.
  task automatic step(input bit sel, input string tag,
                      input logic e, input logic d, input logic en, input logic ng,
                      input logic [3:0] xpe, input logic [3:0] xpd,
                      input logic [1:0] xg, input logic [1:0] xu, input logic xf);
    drive(sel, e, d, en, ng);
    push_exp(sel, tag, xpe, xpd, xg, xu, xf);
    @(posedge clock);
    #1;
    check_pop(sel);
  endtask

  // Immediate check with no clock edge (reset behaviour).
  task automatic check_now(input bit sel, input string tag,
                           input logic [3:0] xpe, input logic [3:0] xpd,
                           input logic [1:0] xg, input logic [1:0] xu, input logic xf);
    push_exp(sel, tag, xpe, xpd, xg, xu, xf);
    check_pop(sel);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    #10;
    check_now(1'b0, "reset_a", 4'd0, 4'd0, 2'd0, 2'd0, 1'b0);
    check_now(1'b1, "reset_b", 4'd0, 4'd0, 2'd0, 2'd0, 1'b0);
    @(negedge clock);
    reset = 1'b1;

    // Seven single-cycle left pulses: 1..7, win on the 7th edge.
    for (int i = 1; i <= 7; i++) begin
      step(1'b0, "win7", 1'b1, 1'b0, 1'b1, 1'b0, 4'(i), 4'd0,
           (i == 7) ? 2'd1 : 2'd0, 2'd1, (i == 7));
      step(1'b0, "win7_lo", 1'b0, 1'b0, 1'b1, 1'b0, 4'(i), 4'd0,
           (i == 7) ? 2'd1 : 2'd0, 2'd1, (i == 7));
    end

    // Match over: further points ignored.
    step(1'b0, "fim_hold",    1'b0, 1'b1, 1'b1, 1'b0, 4'd7, 4'd0, 2'd1, 2'd1, 1'b1);
    step(1'b0, "fim_hold_lo", 1'b0, 1'b0, 1'b1, 1'b0, 4'd7, 4'd0, 2'd1, 2'd1, 1'b1);
    step(1'b0, "fim_hold_e",  1'b1, 1'b0, 1'b1, 1'b0, 4'd7, 4'd0, 2'd1, 2'd1, 1'b1);

    // novo_jogo wins over a coincident left rising edge (left was held high
    // above, so drop it first to make a fresh rising edge).
    step(1'b0, "pre_novo", 1'b0, 1'b0, 1'b1, 1'b0, 4'd7, 4'd0, 2'd1, 2'd1, 1'b1);
    step(1'b0, "novo",     1'b1, 1'b0, 1'b1, 1'b1, 4'd0, 4'd0, 2'd0, 2'd0, 1'b0);
    step(1'b0, "novo_lo",  1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 4'd0, 2'd0, 2'd0, 1'b0);

    // Right held for 20 cycles counts once.
    for (int i = 0; i < 20; i++)
      step(1'b0, "held", 1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 4'd1, 2'd0, 2'd2, 1'b0);
    step(1'b0, "held_lo", 1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 4'd1, 2'd0, 2'd2, 1'b0);

    // Simultaneous rising edges are discarded.
    step(1'b0, "simul",    1'b1, 1'b1, 1'b1, 1'b0, 4'd0, 4'd1, 2'd0, 2'd2, 1'b0);
    step(1'b0, "simul_lo", 1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 4'd1, 2'd0, 2'd2, 1'b0);

    // Pulse while disabled is not counted; the level still high when enable
    // rises is not a new edge either.
    step(1'b0, "en0",      1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 4'd1, 2'd0, 2'd2, 1'b0);
    step(1'b0, "en_rise",  1'b1, 1'b0, 1'b1, 1'b0, 4'd0, 4'd1, 2'd0, 2'd2, 1'b0);
    step(1'b0, "en_lo",    1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 4'd1, 2'd0, 2'd2, 1'b0);
    step(1'b0, "after_en", 1'b1, 1'b0, 1'b1, 1'b0, 4'd1, 4'd1, 2'd0, 2'd1, 1'b0);
    step(1'b0, "after_lo", 1'b0, 1'b0, 1'b1, 1'b0, 4'd1, 4'd1, 2'd0, 2'd1, 1'b0);

    // Level held through reset counts on the first enabled edge after release.
    drive(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    #5;
    reset = 1'b0;
    #2;
    check_now(1'b0, "rst_async", 4'd0, 4'd0, 2'd0, 2'd0, 1'b0);
    @(negedge clock);
    reset = 1'b1;
    step(1'b0, "rst_held",    1'b1, 1'b0, 1'b1, 1'b0, 4'd1, 4'd0, 2'd0, 2'd1, 1'b0);
    step(1'b0, "rst_held_lo", 1'b0, 1'b0, 1'b1, 1'b0, 4'd1, 4'd0, 2'd0, 2'd1, 1'b0);

    // Drive to 3-2, then reset between edges.
    step(1'b0, "to32", 1'b1, 1'b0, 1'b1, 1'b0, 4'd2, 4'd0, 2'd0, 2'd1, 1'b0);
    step(1'b0, "to32", 1'b0, 1'b0, 1'b1, 1'b0, 4'd2, 4'd0, 2'd0, 2'd1, 1'b0);
    step(1'b0, "to32", 1'b1, 1'b0, 1'b1, 1'b0, 4'd3, 4'd0, 2'd0, 2'd1, 1'b0);
    step(1'b0, "to32", 1'b0, 1'b0, 1'b1, 1'b0, 4'd3, 4'd0, 2'd0, 2'd1, 1'b0);
    step(1'b0, "to32", 1'b0, 1'b1, 1'b1, 1'b0, 4'd3, 4'd1, 2'd0, 2'd2, 1'b0);
    step(1'b0, "to32", 1'b0, 1'b0, 1'b1, 1'b0, 4'd3, 4'd1, 2'd0, 2'd2, 1'b0);
    step(1'b0, "to32", 1'b0, 1'b1, 1'b1, 1'b0, 4'd3, 4'd2, 2'd0, 2'd2, 1'b0);
    step(1'b0, "to32", 1'b0, 1'b0, 1'b1, 1'b0, 4'd3, 4'd2, 2'd0, 2'd2, 1'b0);
    #10;
    reset = 1'b0;
    #2;
    check_now(1'b0, "rst_mid", 4'd0, 4'd0, 2'd0, 2'd0, 1'b0);
    @(negedge clock);
    reset = 1'b1;
    step(1'b0, "resume",    1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 4'd1, 2'd0, 2'd2, 1'b0);
    step(1'b0, "resume_lo", 1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 4'd1, 2'd0, 2'd2, 1'b0);

    // Win-by-two instance: alternate to 3-3.
    for (int i = 1; i <= 3; i++) begin
      step(1'b1, "b_up_e",  1'b1, 1'b0, 1'b1, 1'b0, 4'(i), 4'(i-1), 2'd0, 2'd1, 1'b0);
      step(1'b1, "b_up_lo", 1'b0, 1'b0, 1'b1, 1'b0, 4'(i), 4'(i-1), 2'd0, 2'd1, 1'b0);
      step(1'b1, "b_up_d",  1'b0, 1'b1, 1'b1, 1'b0, 4'(i), 4'(i),   2'd0, 2'd2, 1'b0);
      step(1'b1, "b_up_lo", 1'b0, 1'b0, 1'b1, 1'b0, 4'(i), 4'(i),   2'd0, 2'd2, 1'b0);
    end
    step(1'b1, "b_43",      1'b1, 1'b0, 1'b1, 1'b0, 4'd4, 4'd3, 2'd0, 2'd1, 1'b0);
    step(1'b1, "b_43_lo",   1'b0, 1'b0, 1'b1, 1'b0, 4'd4, 4'd3, 2'd0, 2'd1, 1'b0);
    step(1'b1, "b_wrap",    1'b0, 1'b1, 1'b1, 1'b0, 4'd3, 4'd3, 2'd0, 2'd2, 1'b0);
    step(1'b1, "b_wrap_lo", 1'b0, 1'b0, 1'b1, 1'b0, 4'd3, 4'd3, 2'd0, 2'd2, 1'b0);
    step(1'b1, "b_43b",     1'b1, 1'b0, 1'b1, 1'b0, 4'd4, 4'd3, 2'd0, 2'd1, 1'b0);
    step(1'b1, "b_43b_lo",  1'b0, 1'b0, 1'b1, 1'b0, 4'd4, 4'd3, 2'd0, 2'd1, 1'b0);
    step(1'b1, "b_win",     1'b1, 1'b0, 1'b1, 1'b0, 4'd5, 4'd3, 2'd1, 2'd1, 1'b1);
    step(1'b1, "b_win_lo",  1'b0, 1'b0, 1'b1, 1'b0, 4'd5, 4'd3, 2'd1, 2'd1, 1'b1);
    step(1'b1, "b_fim",     1'b0, 1'b1, 1'b1, 1'b0, 4'd5, 4'd3, 2'd1, 2'd1, 1'b1);
    step(1'b1, "b_fim_lo",  1'b0, 1'b0, 1'b1, 1'b0, 4'd5, 4'd3, 2'd1, 2'd1, 1'b1);
    step(1'b1, "b_novo",    1'b0, 1'b0, 1'b1, 1'b1, 4'd0, 4'd0, 2'd0, 2'd0, 1'b0);
    step(1'b1, "b_again",   1'b1, 1'b0, 1'b1, 1'b0, 4'd1, 4'd0, 2'd0, 2'd1, 1'b0);
    step(1'b1, "b_again_lo",1'b0, 1'b0, 1'b1, 1'b0, 4'd1, 4'd0, 2'd0, 2'd1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
